// File: rtl/mux_rr_arbiter_if.sv
// rtl/mux_rr_arbiter_if.sv - requester and shared-mux signal bundle for mux_rr_arbiter
// slave is the arbiter side; master is the requesters plus the external mux.
interface mux_rr_arbiter_if #(parameter int N = 2);
  logic [3:0]     req;
  logic [4*N-1:0] c_in;
  logic [4*N-1:0] d_in;
  logic [7:0]     op_in;
  logic [3:0]     gnt;
  logic [N-1:0]   mux_C;
  logic [N-1:0]   mux_D;
  logic [1:0]     mux_opcode;
  logic [N-1:0]   mux_F;
  logic           res_valid;
  logic [1:0]     res_id;
  logic [N-1:0]   res_F;

  modport slave (
    input  req, c_in, d_in, op_in, mux_F,
    output gnt, mux_C, mux_D, mux_opcode, res_valid, res_id, res_F
  );

  modport master (
    output req, c_in, d_in, op_in, mux_F,
    input  gnt, mux_C, mux_D, mux_opcode, res_valid, res_id, res_F
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter sharing one combinational 4:1 opcode mux among four requesters
// MUX_ARB_FIXED_PRIO_EN: replace round-robin with fixed priority (requester 0 highest).
module mux_rr_arbiter #(
  parameter int N = 2
) (
  input  logic            clk,
  input  logic            rst,
  mux_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state_q, state_d;
  logic [3:0]     gnt_q, gnt_d;
  logic [N-1:0]   mux_c_q, mux_c_d;
  logic [N-1:0]   mux_d_q, mux_d_d;
  logic [1:0]     mux_op_q, mux_op_d;
  logic [1:0]     w_q, w_d;
  logic           res_valid_q, res_valid_d;
  logic [1:0]     res_id_q, res_id_d;
  logic [N-1:0]   res_f_q, res_f_d;
  logic [1:0]     win;
  logic           win_vld;
`ifndef MUX_ARB_FIXED_PRIO_EN
  logic [1:0]     ptr_q, ptr_d;
`endif

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    win     = 2'd0;
    win_vld = |bus.req;
`ifdef MUX_ARB_FIXED_PRIO_EN
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[i]) win = 2'(i);
    end
`else
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = 4'd0;
    mux_c_d     = mux_c_q;
    mux_d_d     = mux_d_q;
    mux_op_d    = mux_op_q;
    w_d         = w_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_f_d     = res_f_q;
`ifndef MUX_ARB_FIXED_PRIO_EN
    ptr_d       = ptr_q;
`endif
    if (state_q == IDLE) begin
      if (win_vld) begin
        mux_c_d  = bus.c_in[win*N +: N];
        mux_d_d  = bus.d_in[win*N +: N];
        mux_op_d = bus.op_in[win*2 +: 2];
        gnt_d    = 4'd1 << win;
        w_d      = win;
`ifndef MUX_ARB_FIXED_PRIO_EN
        ptr_d    = win + 2'd1;
`endif
        state_d  = BUSY;
      end
    end else begin
      // req is ignored here; the shared mux has settled on the granted operands.
      res_f_d     = bus.mux_F;
      res_id_d    = w_q;
      res_valid_d = 1'b1;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= 4'd0;
      mux_c_q     <= '0;
      mux_d_q     <= '0;
      mux_op_q    <= 2'd0;
      w_q         <= 2'd0;
      res_valid_q <= 1'b0;
      res_id_q    <= 2'd0;
      res_f_q     <= '0;
`ifndef MUX_ARB_FIXED_PRIO_EN
      ptr_q       <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      mux_c_q     <= mux_c_d;
      mux_d_q     <= mux_d_d;
      mux_op_q    <= mux_op_d;
      w_q         <= w_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_f_q     <= res_f_d;
`ifndef MUX_ARB_FIXED_PRIO_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.mux_C      = mux_c_q;
  assign bus.mux_D      = mux_d_q;
  assign bus.mux_opcode = mux_op_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_F      = res_f_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - self-checking bench for mux_rr_arbiter with an XOR stand-in for the shared mux
// Honours MUX_ARB_FIXED_PRIO_EN in both the reference model and the literal expectations.
module tb_mux_rr_arbiter;
  localparam int N = 2;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  int   cyc;

  mux_rr_arbiter_if #(.N(N)) bus ();
  mux_rr_arbiter #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.mux_F = bus.mux_C ^ bus.mux_D;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: one transaction in flight, winner chosen by scanning from ptr.
  logic         m_busy;
  int           m_ptr;
  int           m_w;
  logic [3:0]   e_gnt;
  logic [N-1:0] e_c, e_d, e_f;
  logic [1:0]   e_op, e_id;
  logic         e_rv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_ptr = 0; m_w = 0;
      e_gnt = '0; e_c = '0; e_d = '0; e_op = '0; e_rv = 1'b0; e_id = '0; e_f = '0;
    end else if (m_busy) begin
      e_rv   = 1'b1;
      e_id   = 2'(m_w);
      e_f    = e_c ^ e_d;
      e_gnt  = '0;
      m_busy = 1'b0;
    end else begin
      e_rv  = 1'b0;
      e_gnt = '0;
      if (bus.req != 4'd0) begin
        m_w = -1;
        for (int k = 0; k < 4; k++) begin
          int idx;
`ifdef MUX_ARB_FIXED_PRIO_EN
          idx = k;
`else
          idx = (m_ptr + k) % 4;
`endif
          if (m_w < 0 && bus.req[idx]) m_w = idx;
        end
        e_c   = bus.c_in[m_w*N +: N];
        e_d   = bus.d_in[m_w*N +: N];
        e_op  = bus.op_in[m_w*2 +: 2];
        e_gnt = 4'd1 << m_w;
        m_ptr = (m_w + 1) % 4;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if ({bus.gnt, bus.mux_C, bus.mux_D, bus.mux_opcode, bus.res_valid, bus.res_id, bus.res_F} !==
          {e_gnt, e_c, e_d, e_op, e_rv, e_id, e_f}) begin
        n_fail++;
        $display("FAIL model_cycle%0d got gnt=%b C=%b D=%b op=%b rv=%b id=%0d F=%b want gnt=%b C=%b D=%b op=%b rv=%b id=%0d F=%b",
                 cyc, bus.gnt, bus.mux_C, bus.mux_D, bus.mux_opcode, bus.res_valid, bus.res_id, bus.res_F,
                 e_gnt, e_c, e_d, e_op, e_rv, e_id, e_f);
      end
    end
  end

  // Observed grant and result history for the literal checks.
  int g_log[$];
  int r_log[$];
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      for (int i = 0; i < 4; i++) if (bus.gnt[i]) g_log.push_back(i);
      if (bus.res_valid) r_log.push_back(int'(bus.res_id));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n, input bit drop);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (drop) bus.req = bus.req & ~bus.gnt;
    end
  endtask

  int base_g, base_r, rsz;

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    bus.req = '0; bus.c_in = '0; bus.d_in = '0; bus.op_in = '0;
    step(2, 0);
    rst = 1'b0;

    // Single requester 2: C=01 D=10 op=10 -> F=11.
    bus.c_in = 8'b00_01_00_00; bus.d_in = 8'b00_10_00_00; bus.op_in = 8'b00_10_00_00;
    bus.req = 4'b0100;
    @(negedge clk);
    chk("t2_gnt", int'(bus.gnt), 4);
    chk("t2_mux_C", int'(bus.mux_C), 1);
    chk("t2_mux_D", int'(bus.mux_D), 2);
    chk("t2_mux_op", int'(bus.mux_opcode), 2);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("t2_res_valid", int'(bus.res_valid), 1);
    chk("t2_res_id", int'(bus.res_id), 2);
    chk("t2_res_F", int'(bus.res_F), 3);

    // All four from reset, each drops on its grant.
    rst = 1'b1; #1; rst = 1'b0;
    bus.c_in = 8'b11_10_01_00; bus.d_in = 8'b00_01_11_10; bus.op_in = 8'b01_10_11_00;
    base_g = g_log.size(); base_r = r_log.size();
    @(negedge clk);
    bus.req = 4'b1111;
    step(9, 1);
    chk("t3_ngrants", g_log.size() - base_g, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t3_grant%0d", k), g_log[base_g + k], k);
      chk($sformatf("t3_res_id%0d", k), r_log[base_r + k], k);
    end

    // Requesters 0 and 3 held continuously.
    base_g = g_log.size();
    bus.req = 4'b1001;
    step(8, 0);
    bus.req = 4'b0000;
    step(2, 0);
    for (int k = 0; k < 4; k++) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
      chk($sformatf("t4_grant%0d", k), g_log[base_g + k], 0);
`else
      chk($sformatf("t4_grant%0d", k), g_log[base_g + k], (k % 2 == 0) ? 0 : 3);
`endif
    end

    // Requester 3 alone.
    base_g = g_log.size();
    bus.req = 4'b1000;
    step(3, 1);
    chk("t6_grant3", g_log[base_g], 3);

    // Reset while BUSY discards the operation.
    bus.req = 4'b0010;
    @(posedge clk);
    #1 bus.req = 4'b0000;
    chk("t5_gnt_before_rst", int'(bus.gnt), 2);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_gnt", int'(bus.gnt), 0);
    chk("t5_rst_mux", int'({bus.mux_C, bus.mux_D, bus.mux_opcode}), 0);
    chk("t5_rst_res", int'({bus.res_valid, bus.res_id, bus.res_F}), 0);
    rsz = r_log.size();
    step(1, 0);
    rst = 1'b0;
    step(2, 0);
    chk("t5_no_result", r_log.size(), rsz);
    base_g = g_log.size();
    bus.req = 4'b1001;
    step(1, 1);
    chk("t5_grant_after_rst", g_log[base_g], 0);
    bus.req = 4'b0000;
    step(3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
